// File: rtl/scan_refresh_ctrl.sv
// Digit-scan controller for multiplexed seven-segment displays: prescaled slot timing,
// per-digit enable with skip, blanking dead-time per slot, and slot/frame ticks.
module scan_refresh_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [3:0]              hex_out,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    slot_tick,
  output logic                    frame_tick
);

  localparam int unsigned PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    slot_tick_q, slot_tick_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    found_hi, found_lo;
  logic [IDX_W-1:0]        nxt_hi, nxt_lo;

  // Descending scan so the last hit is the lowest qualifying digit.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    nxt_hi   = '0;
    nxt_lo   = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      if (digit_mask[j]) begin
        found_lo = 1'b1;
        nxt_lo   = IDX_W'(j);
        if (j > int'(digit_idx_q)) begin
          found_hi = 1'b1;
          nxt_hi   = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    digit_idx_d  = digit_idx_q;
    mask_d       = mask_q;
    slot_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    if (!en) begin
      state_d = StIdle;
      presc_d = '0;
    end else if (state_q == StIdle) begin
      state_d = StBlank;
      presc_d = '0;
    end else if (presc_q == PW'(PRESCALE - 1)) begin
      state_d     = StBlank;
      presc_d     = '0;
      slot_tick_d = 1'b1;
      mask_d      = digit_mask;
      if (found_hi) begin
        digit_idx_d = nxt_hi;
      end else if (found_lo) begin
        digit_idx_d  = nxt_lo;
        frame_tick_d = 1'b1;
      end else begin
        digit_idx_d = '0;
      end
    end else begin
      presc_d = presc_q + 1'b1;
      state_d = (presc_d >= PW'(BLANK_CYCLES)) ? StShow : StBlank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      digit_idx_q  <= '0;
      mask_q       <= '0;
      slot_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_idx_q  <= digit_idx_d;
      mask_q       <= mask_d;
      slot_tick_q  <= slot_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Anodes decode registered state only, so no input glitch can reach the display.
  always_comb begin
    anode = '1;
    if (state_q == StShow && mask_q[digit_idx_q]) begin
      anode[digit_idx_q] = 1'b0;
    end
  end

  assign hex_out    = digit_data[{digit_idx_q, 2'b00} +: 4];
  assign dp_out     = dp_in[digit_idx_q];
  assign digit_idx  = digit_idx_q;
  assign slot_tick  = slot_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/scan_refresh_ctrl.md
Name: scan_refresh_ctrl

Overview:
- Parametrised digit-scan controller for multiplexed seven-segment displays.
- Generalises the free-running 2-bit refresh counter with:
  - an internal prescaler;
  - a configurable digit count;
  - per-digit enable masking with skip;
  - blanking dead-time at each slot start to prevent ghosting;
  - slot and frame tick outputs.
- Sits between the calculator's result registers and the segment decoder. It drives the anodes directly and selects the nibble to be decoded.

Parameters:
NUM_DIGITS, 4, number of scanned digits (legal 2..8); IDX_W = clog2(NUM_DIGITS), derived, not overridable
PRESCALE, 100000, clk cycles per digit slot (must be >= BLANK_CYCLES+2)
BLANK_CYCLES, 16, cycles at start of each slot with all anodes off (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; low = idle, anodes off
digit_mask  in  NUM_DIGITS  bit i=1: digit i participates in scan
digit_data  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) shown on digit i
dp_in  in  NUM_DIGITS  decimal point per digit
anode  out  NUM_DIGITS  active-low one-hot digit drive; all-ones = off
hex_out  out  4  nibble for current digit, to segment decoder
dp_out  out  1  active-high decimal point for current digit
digit_idx  out  IDX_W  current digit index
slot_tick  out  1  one-cycle pulse on each digit advance
frame_tick  out  1  one-cycle pulse when scan wraps to lowest enabled digit

Behaviour:
- Reset (async, immediate): state=IDLE, presc=0, digit_idx=0, mask_q=0, anode=all ones, slot_tick=0, frame_tick=0.
- FSM states:
  - IDLE: en=0.
  - BLANK: presc < BLANK_CYCLES.
  - SHOW: presc >= BLANK_CYCLES.
- IDLE:
  - presc held at 0, digit_idx held, anodes off, ticks 0.
  - en=1 moves to BLANK with presc=0. No slot_tick is generated.
- Prescaler:
  - While en=1, presc counts 0..PRESCALE-1.
  - BLANK->SHOW when presc reaches BLANK_CYCLES.
- Slot boundary (edge where presc==PRESCALE-1 and en=1):
  - presc<=0, state<=BLANK, slot_tick<=1 for exactly one cycle.
  - mask_q<=digit_mask.
  - digit_idx<=next, where next is the lowest j>digit_idx with digit_mask[j]=1.
  - If no such j exists, next is the lowest j with digit_mask[j]=1, and frame_tick<=1 in the same cycle as slot_tick.
- Single enabled digit: digit_idx is constant and frame_tick pulses every slot.
- digit_mask==0: digit_idx<=0, anodes stay off, slot_tick still pulses, frame_tick never pulses.
- en deasserted in any state: next edge state=IDLE, anode all ones, presc=0, digit_idx unchanged. Re-enable restarts the same digit with a full BLANK period.
- anode is registered-state decode only:
  - anode[i]=0 iff state==SHOW && i==digit_idx && mask_q[i]==1.
  - No combinational path from inputs.
  - At most one bit is low; never low during BLANK or IDLE.
- Mask timing: digit_mask changes take effect only at the next slot boundary, via mask_q and next-index selection. After reset the first slot is idx 0 with mask_q=0, i.e. a dark slot.
- hex_out=digit_data[4*digit_idx+:4] and dp_out=dp_in[digit_idx]. Both are combinational from the registered digit_idx, so data changes pass through in the same cycle.
- Ticks are registered and never asserted in IDLE.

Test Plan:
Common setup: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Reset, en=1, mask=1111 -> first slot dark, then digit_idx 1,2,3,0,1 each for 8 cycles; per slot anode=1111 for 2 cycles then one-hot low (e.g. 1101 for idx 1) for 6 cycles; frame_tick coincides with slot_tick on 3->0 only, period 32 cycles.
2. mask=1010 -> digit_idx sequence 1,3,1,3; anode 1101 / 0111 in SHOW; frame_tick on each 3->1 transition; slot_tick every 8 cycles.
3. mask=0100 -> digit_idx stays 2, anode 1011 in SHOW; slot_tick and frame_tick both pulse every 8 cycles. Then mask=0000 -> anode 1111 permanently from next slot, slot_tick continues, frame_tick stops.
4. en low at presc=5 of idx 2 SHOW -> next edge anode=1111, digit_idx=2 held, no ticks. en high again -> 2 blank cycles, 6 cycles of anode 1011, then advance to idx 3 with slot_tick.
5. digit_data=0x9A3C, dp_in=0010, idx 1 -> hex_out=0x3, dp_out=1. Change nibble 1 to 0x7 mid-slot -> hex_out=0x7 same cycle.
6. rst_n low at presc=4 of idx 3 -> anode=1111 and digit_idx=0 before the next clk edge; ticks 0; after release behaves as scenario 1.
